mc_ctrl: RTL and testbench

//  Multi-cycle MIPS control FSM; sequences each instruction through FETCH/DECODE/EXE/MEM/WB.

---
 rtl/mc_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mc_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXE/MEM/WB sequencing with a
// req/ack memory handshake, datapath strobes/selects and a retired-instruction counter.
module mc_ctrl #(
   parameter int ALUOP_W = 5,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [5:0]         op,
   input  logic [5:0]         funct,
   input  logic               zero,
   input  logic               mem_ack,
   output logic [ALUOP_W-1:0] ALUop,
   output logic [1:0]         alu_b_sel,
   output logic               pc_we,
   output logic [1:0]         pc_src,
   output logic               ir_we,
   output logic               mem_req,
   output logic               mem_we,
   output logic               reg_we,
   output logic               reg_dst,
   output logic               wd_sel,
   output logic               illegal,
   output logic [CNT_W-1:0]   retired
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXE, S_MEM, S_WB
   } state_t;

   typedef enum logic [3:0] {
      C_NONE, C_ADDU, C_SUBU, C_ORI, C_LW, C_SW, C_LUI, C_BEQ, C_J, C_ILLEGAL
   } class_t;

   state_t state, next_state;
   class_t cls, next_cls, dec_cls;
   logic   retire;
   logic [ALUOP_W-1:0] alu_code;
   logic [1:0]         b_code;

   always_comb begin
      dec_cls = C_ILLEGAL;
      case (op)
         6'h00: begin
            if (funct == 6'h21)      dec_cls = C_ADDU;
            else if (funct == 6'h23) dec_cls = C_SUBU;
         end
         6'h0D:   dec_cls = C_ORI;
         6'h23:   dec_cls = C_LW;
         6'h2B:   dec_cls = C_SW;
         6'h0F:   dec_cls = C_LUI;
         6'h04:   dec_cls = C_BEQ;
         6'h02:   dec_cls = C_J;
         default: dec_cls = C_ILLEGAL;
      endcase
   end

   // ALU controls come only from the latched class, so EXE/MEM/WB hold them steady
   always_comb begin
      alu_code = '0;
      b_code   = 2'd0;
      case (cls)
         C_SUBU:  alu_code = ALUOP_W'(1);
         C_BEQ:   alu_code = ALUOP_W'(1);
         C_ORI:   begin alu_code = ALUOP_W'(2); b_code = 2'd1; end
         C_LW:    begin alu_code = ALUOP_W'(3); b_code = 2'd2; end
         C_SW:    begin alu_code = ALUOP_W'(4); b_code = 2'd2; end
         C_LUI:   begin alu_code = ALUOP_W'(5); b_code = 2'd1; end
         default: begin alu_code = '0; b_code = 2'd0; end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         cls     <= C_NONE;
         retired <= '0;
      end else begin
         state <= next_state;
         cls   <= next_cls;
         if (retire) retired <= retired + CNT_W'(1);
      end
   end

   always_comb begin
      next_state = state;
      next_cls   = cls;
      retire     = 1'b0;
      ALUop      = '0;
      alu_b_sel  = 2'd0;
      pc_we      = 1'b0;
      pc_src     = 2'd0;
      ir_we      = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      wd_sel     = 1'b0;
      illegal    = 1'b0;
      case (state)
         S_IDLE: next_state = S_FETCH;
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_we      = 1'b1;
               pc_we      = 1'b1;
               next_state = S_DECODE;
            end
         end
         // The class register is not loaded yet here, so decode op directly
         S_DECODE: begin
            next_cls = dec_cls;
            if (dec_cls == C_ILLEGAL) begin
               illegal    = 1'b1;
               next_state = S_FETCH;
            end else if (dec_cls == C_J) begin
               pc_we      = 1'b1;
               pc_src     = 2'd2;
               retire     = 1'b1;
               next_state = S_FETCH;
            end else begin
               next_state = S_EXE;
            end
         end
         S_EXE: begin
            ALUop     = alu_code;
            alu_b_sel = b_code;
            case (cls)
               C_BEQ: begin
                  pc_we      = zero;
                  pc_src     = 2'd1;
                  retire     = 1'b1;
                  next_state = S_FETCH;
               end
               C_LW, C_SW:                   next_state = S_MEM;
               C_ADDU, C_SUBU, C_ORI, C_LUI: next_state = S_WB;
               default:                      next_state = S_FETCH;
            endcase
         end
         S_MEM: begin
            ALUop     = alu_code;
            alu_b_sel = b_code;
            mem_req   = 1'b1;
            mem_we    = (cls == C_SW);
            if (mem_ack) begin
               if (cls == C_SW) begin
                  retire     = 1'b1;
                  next_state = S_FETCH;
               end else begin
                  next_state = S_WB;
               end
            end
         end
         S_WB: begin
            ALUop      = alu_code;
            alu_b_sel  = b_code;
            reg_we     = 1'b1;
            reg_dst    = (cls == C_ADDU) || (cls == C_SUBU);
            wd_sel     = (cls == C_LW);
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         default: next_state = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed instruction sequences plus randomized
// instruction/wait-state mixes, checked cycle by cycle against a per-instruction phase model.
module tb_mc_ctrl;

   logic        clk;
   logic        rst_n;
   logic [5:0]  op_in;
   logic [5:0]  funct_in;
   logic        zero;
   logic        mem_ack;
   logic [4:0]  ALUop;
   logic [1:0]  alu_b_sel;
   logic        pc_we;
   logic [1:0]  pc_src;
   logic        ir_we;
   logic        mem_req;
   logic        mem_we;
   logic        reg_we;
   logic        reg_dst;
   logic        wd_sel;
   logic        illegal;
   logic [31:0] retired;
   logic [16:0] obs_vec;

   int          compare_count = 0;
   int          fail_count    = 0;
   logic [31:0] model_retired = 0;

   typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_LUI, K_BEQ, K_J, K_ILL} kind_t;

   mc_ctrl #(.ALUOP_W(5), .CNT_W(32)) dut (
      .clk(clk), .reset(rst_n), .op(op_in), .funct(funct_in), .zero(zero),
      .mem_ack(mem_ack), .ALUop(ALUop), .alu_b_sel(alu_b_sel), .pc_we(pc_we),
      .pc_src(pc_src), .ir_we(ir_we), .mem_req(mem_req), .mem_we(mem_we),
      .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel), .illegal(illegal),
      .retired(retired)
   );

   assign obs_vec = {ALUop, alu_b_sel, pc_we, pc_src, ir_we, mem_req, mem_we,
                     reg_we, reg_dst, wd_sel, illegal};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compare_count++;
      if (obs !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [16:0] mk(input int alu, input int bsel, input bit pcwe,
                                      input int pcsrc, input bit irwe, input bit mreq,
                                      input bit mwe, input bit rwe, input bit rdst,
                                      input bit wds, input bit ill);
      return {5'(alu), 2'(bsel), pcwe, 2'(pcsrc), irwe, mreq, mwe, rwe, rdst, wds, ill};
   endfunction

   function automatic kind_t classify(input logic [5:0] o, input logic [5:0] f);
      if (o == 6'h00 && f == 6'h21) return K_ADDU;
      if (o == 6'h00 && f == 6'h23) return K_SUBU;
      if (o == 6'h0D) return K_ORI;
      if (o == 6'h23) return K_LW;
      if (o == 6'h2B) return K_SW;
      if (o == 6'h0F) return K_LUI;
      if (o == 6'h04) return K_BEQ;
      if (o == 6'h02) return K_J;
      return K_ILL;
   endfunction

   function automatic int alu_of(input kind_t k);
      case (k)
         K_SUBU, K_BEQ: return 1;
         K_ORI:         return 2;
         K_LW:          return 3;
         K_SW:          return 4;
         K_LUI:         return 5;
         default:       return 0;
      endcase
   endfunction

   function automatic int bsel_of(input kind_t k);
      case (k)
         K_ORI, K_LUI: return 1;
         K_LW, K_SW:   return 2;
         default:      return 0;
      endcase
   endfunction

   // Called at posedge+1: drive inputs, check at negedge, advance to next posedge+1
   task automatic applyStimulus(input bit ack, input bit z, input logic [16:0] exp,
                                input string tag, input bit retire_now);
      mem_ack = ack;
      zero    = z;
      @(negedge clk);
      checkOutput({tag, "_outs"}, 32'(obs_vec), 32'(exp));
      checkOutput({tag, "_retired"}, retired, model_retired);
      @(posedge clk);
      #1;
      if (retire_now) model_retired = model_retired + 1;
   endtask

   task automatic runInstr(input logic [5:0] o, input logic [5:0] f, input int fwait,
                           input int mwait, input bit z);
      kind_t k;
      int    a;
      int    b;
      k = classify(o, f);
      a = alu_of(k);
      b = bsel_of(k);
      for (int i = 0; i < fwait; i++)
         applyStimulus(1'b0, 1'($urandom), mk(0,0,0,0,0,1,0,0,0,0,0), "fetch_wait", 1'b0);
      applyStimulus(1'b1, 1'($urandom), mk(0,0,1,0,1,1,0,0,0,0,0), "fetch_ack", 1'b0);
      op_in    = o;
      funct_in = f;
      if (k == K_ILL) begin
         applyStimulus(1'($urandom), 1'($urandom), mk(0,0,0,0,0,0,0,0,0,0,1), "dec_ill", 1'b0);
         return;
      end
      if (k == K_J) begin
         applyStimulus(1'($urandom), 1'($urandom), mk(0,0,1,2,0,0,0,0,0,0,0), "dec_j", 1'b1);
         return;
      end
      applyStimulus(1'($urandom), 1'($urandom), mk(0,0,0,0,0,0,0,0,0,0,0), "decode", 1'b0);
      if (k == K_BEQ) begin
         applyStimulus(1'($urandom), z, mk(a,b,z,1,0,0,0,0,0,0,0), "exe_beq", 1'b1);
         return;
      end
      applyStimulus(1'($urandom), 1'($urandom), mk(a,b,0,0,0,0,0,0,0,0,0), "exe", 1'b0);
      if (k == K_LW || k == K_SW) begin
         for (int i = 0; i < mwait; i++)
            applyStimulus(1'b0, 1'($urandom), mk(a,b,0,0,0,1,k == K_SW,0,0,0,0), "mem_wait", 1'b0);
         applyStimulus(1'b1, 1'($urandom), mk(a,b,0,0,0,1,k == K_SW,0,0,0,0), "mem_ack", k == K_SW);
         if (k == K_SW) return;
      end
      applyStimulus(1'($urandom), 1'($urandom),
                    mk(a,b,0,0,0,0,0,1,(k == K_ADDU) || (k == K_SUBU),k == K_LW,0), "wb", 1'b1);
   endtask

   initial begin
      logic [5:0] ops [8];
      logic [5:0] fns [8];
      int         pick;
      logic [5:0] o;
      logic [5:0] f;
      ops = '{6'h00, 6'h00, 6'h0D, 6'h23, 6'h2B, 6'h0F, 6'h04, 6'h02};
      fns = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
      rst_n    = 1'b0;
      mem_ack  = 1'b0;
      zero     = 1'b0;
      op_in    = 6'h00;
      funct_in = 6'h00;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_outs", 32'(obs_vec), 32'd0);
      checkOutput("reset_retired", retired, 32'd0);
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,0), "idle", 1'b0);

      $display("[TB] directed sequences");
      runInstr(6'h00, 6'h21, 0, 0, 1'b0);
      runInstr(6'h23, 6'h00, 3, 2, 1'b0);
      runInstr(6'h04, 6'h00, 0, 0, 1'b1);
      runInstr(6'h04, 6'h00, 0, 0, 1'b0);
      runInstr(6'h2B, 6'h00, 0, 1, 1'b0);
      runInstr(6'h02, 6'h00, 0, 0, 1'b0);
      runInstr(6'h0D, 6'h00, 0, 0, 1'b0);
      runInstr(6'h0F, 6'h00, 0, 0, 1'b0);
      runInstr(6'h3F, 6'h00, 0, 0, 1'b0);
      runInstr(6'h00, 6'h20, 1, 0, 1'b0);
      runInstr(6'h00, 6'h23, 0, 0, 1'b0);

      $display("[TB] randomized sequences");
      for (int n = 0; n < 200; n++) begin
         pick = $urandom_range(9, 0);
         if (pick < 8) begin
            o = ops[pick];
            f = fns[pick];
         end else begin
            o = 6'($urandom);
            f = 6'($urandom);
         end
         runInstr(o, f, $urandom_range(3, 0), $urandom_range(3, 0), 1'($urandom));
      end

      $display("[TB] reset during pending sw");
      applyStimulus(1'b1, 1'b0, mk(0,0,1,0,1,1,0,0,0,0,0), "rst_fetch", 1'b0);
      op_in    = 6'h2B;
      funct_in = 6'h00;
      applyStimulus(1'b0, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,0), "rst_decode", 1'b0);
      applyStimulus(1'b0, 1'b0, mk(4,2,0,0,0,0,0,0,0,0,0), "rst_exe", 1'b0);
      applyStimulus(1'b0, 1'b0, mk(4,2,0,0,0,1,1,0,0,0,0), "rst_mem_wait", 1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
      checkOutput("rst_mid_outs", 32'(obs_vec), 32'd0);
      checkOutput("rst_mid_retired", retired, 32'd0);
      model_retired = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, mk(0,0,0,0,0,0,0,0,0,0,0), "rst_idle", 1'b0);
      runInstr(6'h00, 6'h21, 0, 0, 1'b0);
      runInstr(6'h2B, 6'h00, 2, 0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
      $finish;
   end

endmodule
